// File: rtl/regfile_host_arbiter_if.sv
// regfile_host_arbiter_if: host request/response and register-file port bundle for the arbiter
interface regfile_host_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int N_REG = 4,
  parameter int ADDR_WIDTH = $clog2(N_REG) + 1
);
  logic [1:0] req_valid, req_write, req_ready, rsp_valid;
  logic [1:0][ADDR_WIDTH-1:0] req_addr;
  logic [1:0][DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH-1:0] rsp_rdata, rf_wr_data, rf_rd_data;
  logic rsp_err, rf_wr_en, rf_rd_valid, busy;
  logic [ADDR_WIDTH-1:0] rf_wr_addr, rf_rd_addr;
  modport slave (
    input req_valid, req_write, req_addr, req_wdata, rf_rd_data, rf_rd_valid,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rf_wr_en, rf_wr_addr, rf_wr_data, rf_rd_addr, busy
  );
  modport master (
    output req_valid, req_write, req_addr, req_wdata, rf_rd_data, rf_rd_valid,
    input req_ready, rsp_valid, rsp_rdata, rsp_err, rf_wr_en, rf_wr_addr, rf_wr_data, rf_rd_addr, busy
  );
endinterface

// File: rtl/regfile_host_arbiter.sv
// regfile_host_arbiter: two-host round-robin arbiter sequencing single-beat accesses onto a register file
module regfile_host_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int N_REG = 4,
  parameter int READ_LATENCY = 0,
  parameter int ADDR_WIDTH = $clog2(N_REG) + 1
) (
  input logic clk,
  input logic rst,
  regfile_host_arbiter_if.slave bus
);
  localparam logic [ADDR_WIDTH-1:0] PARK = ADDR_WIDTH'(N_REG);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic last_grant, t_grant, t_write, g, oob, accept, wr_en, done, err;
  logic [ADDR_WIDTH-1:0] t_addr, g_addr;
  logic [DATA_WIDTH-1:0] t_wdata, rdata;
  logic [1:0] rsp_valid;
  always_comb begin
    g = &bus.req_valid ? ~last_grant : bus.req_valid[1];
    g_addr = bus.req_addr[g];
    oob = g_addr >= PARK;
    accept = state == IDLE && |bus.req_valid && !rst;
    wr_en = state == ISSUE && t_write && !rst;
    done = state == WAIT || (state == ISSUE && (t_write || READ_LATENCY == 0));
  end
  assign bus.req_ready = {accept && g, accept && !g};
  assign bus.rsp_valid = rst ? 2'b00 : rsp_valid;
  assign bus.rsp_rdata = rdata;
  assign bus.rsp_err = err;
  assign bus.rf_wr_en = wr_en;
  // parked write address keeps the regfile bypass from matching any real read address
  assign bus.rf_wr_addr = wr_en ? t_addr : PARK;
  assign bus.rf_wr_data = t_wdata;
  assign bus.rf_rd_addr = (state == ISSUE || state == WAIT) && !t_write && !rst ? t_addr : '0;
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      last_grant <= 1'b1;
      t_grant <= 1'b0;
      t_write <= 1'b0;
      t_addr <= '0;
      t_wdata <= '0;
      rsp_valid <= '0;
      rdata <= '0;
      err <= 1'b0;
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: if (accept) begin
          last_grant <= g;
          t_grant <= g;
          t_write <= bus.req_write[g];
          t_addr <= g_addr;
          if (bus.req_write[g] && !oob) t_wdata <= bus.req_wdata[g];
          rdata <= '0;
          err <= oob;
          rsp_valid <= oob ? {g, !g} : 2'b00;
          state <= oob ? RESP : ISSUE;
        end
        ISSUE, WAIT: begin
          state <= done ? RESP : WAIT;
          rsp_valid <= done ? {t_grant, !t_grant} : 2'b00;
          if (done && !t_write) begin
            rdata <= bus.rf_rd_data;
            err <= !bus.rf_rd_valid;
          end
        end
        default: begin
          state <= IDLE;
          rdata <= '0;
          err <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_regfile_host_arbiter.sv
// tb_regfile_host_arbiter: directed vector bench with regfile models for both read latencies
module tb_regfile_host_arbiter;
  localparam logic [15:0] RV [4] = '{16'h0000, 16'h2580, 16'h0000, 16'h00A5};
  typedef struct {int r; logic w; logic [2:0] a; logic [15:0] d; logic [15:0] er; logic ee;} vec_t;
  logic clk = 1'b0, rst = 1'b1, rf_init = 1'b1;
  int errors = 0, checks = 0;
  logic [15:0] m0 [4];
  always #5 clk = ~clk;
  regfile_host_arbiter_if b0 ();
  regfile_host_arbiter_if b1 ();
  regfile_host_arbiter #(.READ_LATENCY(0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  regfile_host_arbiter #(.READ_LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  // combinational regfile whose bypass compares addresses only
  always @(posedge clk)
    if (rf_init) m0 <= RV;
    else if (b0.rf_wr_en && b0.rf_wr_addr < 3'd4) m0[b0.rf_wr_addr[1:0]] <= b0.rf_wr_data;
  assign b0.rf_rd_valid = b0.rf_rd_addr < 3'd4;
  assign b0.rf_rd_data = !b0.rf_rd_valid ? 16'h0 :
                         b0.rf_wr_addr == b0.rf_rd_addr ? b0.rf_wr_data : m0[b0.rf_rd_addr[1:0]];
  always @(posedge clk) begin
    b1.rf_rd_valid <= b1.rf_rd_addr < 3'd4;
    b1.rf_rd_data <= b1.rf_rd_addr < 3'd4 ? RV[b1.rf_rd_addr[1:0]] : 16'h0;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", n, act, exp);
    end
  endtask
  function automatic logic [15:0] f(input int r, input int k);
    return 16'(32'h0A00 + r * 16 + k);
  endfunction
  task automatic txn(input string n, input int r, input logic w, input logic [2:0] a,
                     input logic [15:0] d, input logic [15:0] er, input logic ee);
    logic [1:0] oh;
    oh = r == 0 ? 2'b01 : 2'b10;
    b0.req_valid[r] = 1'b1;
    b0.req_write[r] = w;
    b0.req_addr[r] = a;
    b0.req_wdata[r] = d;
    #1 chk({n, "_ready"}, 32'(b0.req_ready), 32'(oh));
    @(posedge clk);
    #1 b0.req_valid = 2'b00;
    chk({n, "_t1_wr_en"}, 32'(b0.rf_wr_en), 32'(w && a < 3'd4));
    if (a < 3'd4 && w) begin
      chk({n, "_t1_wr_addr"}, 32'(b0.rf_wr_addr), 32'(a));
      chk({n, "_t1_wr_data"}, 32'(b0.rf_wr_data), 32'(d));
    end
    if (a < 3'd4 && !w) begin
      chk({n, "_t1_rd_addr"}, 32'(b0.rf_rd_addr), 32'(a));
      chk({n, "_t1_wr_park"}, 32'(b0.rf_wr_addr), 32'd4);
    end
    if (a < 3'd4) begin
      chk({n, "_t1_rsp"}, 32'(b0.rsp_valid), 0);
      @(posedge clk);
      #1 chk({n, "_t2_wr_en"}, 32'(b0.rf_wr_en), 0);
    end
    chk({n, "_rsp_valid"}, 32'(b0.rsp_valid), 32'(oh));
    chk({n, "_rsp_rdata"}, 32'(b0.rsp_rdata), 32'(er));
    chk({n, "_rsp_err"}, 32'(b0.rsp_err), 32'(ee));
    @(posedge clk);
    #1 chk({n, "_rsp_clear"}, 32'(b0.rsp_valid), 0);
    chk({n, "_idle"}, 32'(b0.busy), 0);
  endtask
  initial begin
    vec_t v [10];
    logic [18:0] wlog [$];
    int glog [$];
    int gcnt [2];
    v = '{'{0, 1'b1, 3'd0, 16'h000B, 16'h0000, 1'b0},
          '{1, 1'b0, 3'd1, 16'h0000, 16'h2580, 1'b0},
          '{0, 1'b1, 3'd5, 16'hFFFF, 16'h0000, 1'b1},
          '{0, 1'b0, 3'd0, 16'h0000, 16'h000B, 1'b0},
          '{1, 1'b1, 3'd0, 16'h0003, 16'h0000, 1'b0},
          '{0, 1'b0, 3'd0, 16'h0000, 16'h0003, 1'b0},
          '{1, 1'b1, 3'd2, 16'h1234, 16'h0000, 1'b0},
          '{0, 1'b0, 3'd3, 16'h0000, 16'h00A5, 1'b0},
          '{1, 1'b0, 3'd4, 16'h0000, 16'h0000, 1'b1},
          '{1, 1'b0, 3'd7, 16'h0000, 16'h0000, 1'b1}};
    b0.req_valid = 2'b00; b0.req_write = 2'b00; b0.req_addr = '0; b0.req_wdata = '0;
    b1.req_valid = 2'b00; b1.req_write = 2'b00; b1.req_addr = '0; b1.req_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rf_init = 1'b0;
    #1;
    chk("rst_ready", 32'(b0.req_ready), 0);
    chk("rst_rsp_valid", 32'(b0.rsp_valid), 0);
    chk("rst_rsp_rdata", 32'(b0.rsp_rdata), 0);
    chk("rst_rsp_err", 32'(b0.rsp_err), 0);
    chk("rst_wr_en", 32'(b0.rf_wr_en), 0);
    chk("rst_wr_addr", 32'(b0.rf_wr_addr), 4);
    chk("rst_wr_data", 32'(b0.rf_wr_data), 0);
    chk("rst_rd_addr", 32'(b0.rf_rd_addr), 0);
    chk("rst_busy", 32'(b0.busy), 0);
    // registered-read regfile: response one cycle later
    b1.req_valid = 2'b10;
    b1.req_addr[1] = 3'd1;
    #1 chk("l1_ready", 32'(b1.req_ready), 2);
    @(posedge clk);
    #1 b1.req_valid = 2'b00;
    chk("l1_t1_rd_addr", 32'(b1.rf_rd_addr), 1);
    chk("l1_t1_rsp", 32'(b1.rsp_valid), 0);
    @(posedge clk);
    #1 chk("l1_t2_rd_addr", 32'(b1.rf_rd_addr), 1);
    chk("l1_t2_rsp", 32'(b1.rsp_valid), 0);
    @(posedge clk);
    #1 chk("l1_t3_rsp", 32'(b1.rsp_valid), 2);
    chk("l1_t3_rdata", 32'(b1.rsp_rdata), 32'h2580);
    chk("l1_t3_err", 32'(b1.rsp_err), 0);
    @(posedge clk);
    #1 chk("l1_clear", 32'(b1.rsp_valid), 0);
    chk("l1_rd_park", 32'(b1.rf_rd_addr), 0);
    for (int i = 0; i < 10; i++)
      txn($sformatf("vec%0d", i), v[i].r, v[i].w, v[i].a, v[i].d, v[i].er, v[i].ee);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    gcnt = '{0, 0};
    b0.req_write = 2'b11;
    for (int r = 0; r < 2; r++) begin
      b0.req_addr[r] = 3'd0;
      b0.req_wdata[r] = f(r, 0);
    end
    b0.req_valid = 2'b11;
    for (int c = 0; c < 80 && (b0.req_valid != 2'b00 || b0.busy); c++) begin
      #1;
      if (b0.rf_wr_en) wlog.push_back({b0.rf_wr_addr, b0.rf_wr_data});
      for (int r = 0; r < 2; r++) if (b0.req_ready[r]) begin glog.push_back(r); gcnt[r]++; end
      @(posedge clk);
      #1;
      for (int r = 0; r < 2; r++) begin
        b0.req_valid[r] = gcnt[r] < 4;
        b0.req_addr[r] = 3'(gcnt[r]);
        b0.req_wdata[r] = f(r, gcnt[r]);
      end
    end
    b0.req_valid = 2'b00;
    chk("cont_grants", 32'(glog.size()), 8);
    chk("cont_writes", 32'(wlog.size()), 8);
    for (int i = 0; i < glog.size() && i < 8; i++)
      chk($sformatf("cont_grant%0d", i), 32'(glog[i]), 32'(i % 2));
    for (int i = 0; i < wlog.size() && i < 8; i++)
      chk($sformatf("cont_write%0d", i), 32'(wlog[i]), 32'({3'(i / 2), f(i % 2, i / 2)}));
    b0.req_valid = 2'b01;
    b0.req_write = 2'b01;
    b0.req_addr[0] = 3'd1;
    b0.req_wdata[0] = 16'h7777;
    @(posedge clk);
    #1 b0.req_valid = 2'b00;
    chk("mid_in_issue", 32'(b0.rf_wr_en), 1);
    rst = 1'b1;
    #1 chk("mid_rst_wr_en", 32'(b0.rf_wr_en), 0);
    chk("mid_rst_rsp", 32'(b0.rsp_valid), 0);
    chk("mid_rst_wr_addr", 32'(b0.rf_wr_addr), 4);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("mid_busy", 32'(b0.busy), 0);
    chk("mid_wr_en", 32'(b0.rf_wr_en), 0);
    chk("mid_wr_addr", 32'(b0.rf_wr_addr), 4);
    chk("mid_wr_data", 32'(b0.rf_wr_data), 0);
    chk("mid_rd_addr", 32'(b0.rf_rd_addr), 0);
    chk("mid_rsp_rdata", 32'(b0.rsp_rdata), 0);
    chk("mid_rsp_err", 32'(b0.rsp_err), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 chk($sformatf("mid_quiet%0d", i), 32'({b0.rsp_valid, b0.rf_wr_en}), 0);
    end
    txn("after_rst", 0, 1'b0, 3'd1, 16'h0000, 16'h0A11, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_host_arbiter.md
# regfile_host_arbiter

Two-requester round-robin arbiter and transaction sequencer in front of the UART configuration register file. It accepts single-beat read/write requests from two hosts (requester 0 = CPU bus bridge, requester 1 = config loader/debug port) over valid/ready handshakes. It serializes them onto the register file's single write port and read port A, and returns a one-cycle response with read data and an error flag to the granted requester.

## Interface
- DATA_WIDTH, 16, register data width
- N_REG, 4, number of implemented registers; addresses >= N_REG are out-of-bounds (OOB)
- READ_LATENCY, 0, register file read latency (0 or 1); must match the regfile instance
- ADDR_WIDTH, $clog2(N_REG)+1, address width (derived, matches regfile address ports)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester request valid
- req_write  in  2  per-requester 1=write, 0=read
- req_addr  in  2×ADDR_WIDTH  per-requester address
- req_wdata  in  2×DATA_WIDTH  per-requester write data
- req_ready  out  2  per-requester request accepted this cycle
- rsp_valid  out  2  per-requester one-cycle response strobe
- rsp_rdata  out  DATA_WIDTH  read data (shared, qualified by rsp_valid)
- rsp_err  out  1  OOB or invalid-read error (shared, qualified by rsp_valid)
- rf_wr_en  out  1  to regfile wr_en
- rf_wr_addr  out  ADDR_WIDTH  to regfile wr_addr
- rf_wr_data  out  DATA_WIDTH  to regfile wr_data
- rf_rd_addr  out  ADDR_WIDTH  to regfile rd_addr_a
- rf_rd_data  in  DATA_WIDTH  from regfile rd_data_a
- rf_rd_valid  in  1  from regfile rd_valid_a
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: pick one requester among those with req_valid. req_ready[g]=1 combinationally for the grant g only. Latch write, addr, wdata and g into transaction registers.
  - OOB address: go to RESP directly with err=1, rdata=0, no regfile access.
  - Otherwise: go to ISSUE.
- ISSUE, write: rf_wr_en=1 for exactly this cycle, rf_wr_addr/rf_wr_data from the latched transaction, then go to RESP.
- ISSUE, read: rf_rd_addr=latched addr.
  - READ_LATENCY=0: capture rf_rd_data and err=!rf_rd_valid this cycle, then go to RESP.
  - READ_LATENCY=1: go to WAIT with rf_rd_addr held, capture there, then go to RESP.
- RESP: rsp_valid[g]=1 for one cycle; rsp_rdata and rsp_err are valid; then go to IDLE. Write responses carry rdata=0, err=0. There is no response back-pressure.
- Round-robin: a last_grant register updates on every accept.
  - Both requesting: grant the one != last_grant.
  - Single requester: it wins regardless.
  - Reset value last_grant=1, so requester 0 wins the first contention.
- rf_wr_addr parks at N_REG whenever rf_wr_en=0. This keeps the regfile's same-cycle write-to-read bypass from forwarding stale write data into a read.
- rf_rd_addr parks at 0 outside ISSUE/WAIT.
- Requests not granted stay pending; requesters must hold valid/payload until req_ready.

## Timing
- Reset values: FSM=IDLE, req_ready=0 (forced low while rst), rsp_valid=0, rsp_rdata=0, rsp_err=0, rf_wr_en=0, rf_wr_addr=N_REG, rf_wr_data=0, rf_rd_addr=0, busy=0, last_grant=1.
- Accept at cycle T (IDLE). Write: rf_wr_en at T+1, rsp at T+2.
- Read: rsp at T+2 (latency 0) or T+3 (latency 1).
- OOB: rsp at T+1.
- Back-to-back: next accept no earlier than the cycle after RESP. Peak rate is one write per 3 cycles.
- Reset mid-transaction: abort immediately, no rsp_valid, no rf_wr_en in the reset cycle or after. The in-flight request is dropped and not retried.
- req_valid deasserted by a requester before req_ready: no grant, no side effects.

## Test plan
- Single write: req0 write addr 0 data 0x000B at T -> req_ready[0] at T, rf_wr_en=1 addr 0 data 0x000B at T+1, rsp_valid[0]=1 err=0 at T+2.
- Read-after-reset, READ_LATENCY=0: req1 read addr 1 -> rsp_valid[1] at T+2, rsp_rdata=9600 (0x2580), err=0. Repeat with READ_LATENCY=1 -> rsp at T+3.
- Contention: both valid continuously with 4 requests each -> grants alternate 0,1,0,1,…, starting with 0; each write appears on rf_wr_* exactly once, in grant order.
- OOB: req0 write addr 5 data 0xFFFF -> rsp_err=1 at T+1; rf_wr_en never asserts; a subsequent read of addr 0 returns the unchanged value.
- Bypass guard: write addr 0 = 0x0003, then read addr 0 -> rdata 0x0003. Read addr 3 while rf_wr_data last held 0x1234 -> rdata equals stored value, not 0x1234.
- Reset during ISSUE of a write -> no rf_wr_en pulse, no rsp_valid; all outputs at reset values the next cycle; a new request is accepted normally afterwards.
